// File: rtl/alu_unit.sv
// Integer execution unit behind the reservation station: registered single-cycle ALU/branch results
// on the RS result bus. Define ALU_M_EXT_EN to add the sequential RV32M multiply/divide path.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef R_TYPE
`define R_TYPE 7'b0110011
`endif
`ifndef I_TYPE
`define I_TYPE 7'b0010011
`endif
`ifndef B_TYPE
`define B_TYPE 7'b1100011
`endif

module alu_unit #(
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rob_clear,
  input  logic                      valid,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id,
  input  logic [2:0]                op,
  input  logic [6:0]                instr_type,
  input  logic                      op_other,
  input  logic                      op_m,
  input  logic [XLEN-1:0]           v1,
  input  logic [XLEN-1:0]           v2,
  output logic                      alu_busy,
  output logic                      rs_ready,
  output logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
  output logic [XLEN-1:0]           rs_value
);

  // Handshake: an op transfers on a rising edge where valid && rdy && !rob_clear and the unit is idle;
  // the RS keeps valid low while alu_busy is high, and rs_ready marks a result for every edge it is held.
  logic                      rs_ready_q, rs_ready_d;
  logic [ROB_SIZE_WIDTH-1:0] rob_id_q, rob_id_d;
  logic [XLEN-1:0]           value_q, value_d;
  logic [XLEN-1:0]           base_res;
  logic [4:0]                shamt;
  logic                      is_m, idle, m_done;
  logic [ROB_SIZE_WIDTH-1:0] m_tag;
  logic [XLEN-1:0]           m_res;

  assign shamt = v2[4:0];

  always_comb begin
    base_res = '0;
    if (instr_type == `R_TYPE || instr_type == `I_TYPE) begin
      case (op)
        3'b000: base_res = (instr_type == `R_TYPE && op_other) ? v1 - v2 : v1 + v2;
        3'b001: base_res = v1 << shamt;
        3'b010: base_res = {{(XLEN-1){1'b0}}, $signed(v1) < $signed(v2)};
        3'b011: base_res = {{(XLEN-1){1'b0}}, v1 < v2};
        3'b100: base_res = v1 ^ v2;
        3'b101: begin
          if (op_other) base_res = $unsigned($signed(v1) >>> shamt);
          else          base_res = v1 >> shamt;
        end
        3'b110: base_res = v1 | v2;
        default: base_res = v1 & v2;
      endcase
    end else if (instr_type == `B_TYPE) begin
      case (op)
        3'b000:  base_res = {{(XLEN-1){1'b0}}, v1 == v2};
        3'b001:  base_res = {{(XLEN-1){1'b0}}, v1 != v2};
        3'b100:  base_res = {{(XLEN-1){1'b0}}, $signed(v1) < $signed(v2)};
        3'b101:  base_res = {{(XLEN-1){1'b0}}, $signed(v1) >= $signed(v2)};
        3'b110:  base_res = {{(XLEN-1){1'b0}}, v1 < v2};
        3'b111:  base_res = {{(XLEN-1){1'b0}}, v1 >= v2};
        default: base_res = '0;
      endcase
    end
  end

`ifdef ALU_M_EXT_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [32:0]               hi_q, hi_d;
  logic [31:0]               lo_q, lo_d, b_q, b_d;
  logic [2:0]                mop_q, mop_d;
  logic                      neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [ROB_SIZE_WIDTH-1:0] tag_q, tag_d;
  logic                      neg_a, neg_b;
  logic [32:0]               mul_sum, div_shift;
  logic [33:0]               div_trial;
  logic [63:0]               prod_mag, prod;
  logic [31:0]               quo, rem;

  assign is_m     = (instr_type == `R_TYPE) && op_m;
  assign idle     = (state_q == S_IDLE);
  assign alu_busy = (state_q != S_IDLE);
  assign m_done   = (state_q == S_CALC) && (cnt_q == 5'd31);
  assign m_tag    = tag_q;

  // Operands are held as magnitudes; signs are reapplied when the last iteration completes.
  assign neg_a     = v1[31] && (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
  assign neg_b     = v2[31] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
  assign mul_sum   = hi_q + {1'b0, (lo_q[0] ? b_q : 32'd0)};
  assign div_shift = {hi_q[31:0], lo_q[31]};
  assign div_trial = {1'b0, div_shift} - {2'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    mop_d   = mop_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    tag_d   = tag_q;
    if (rob_clear) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (valid && is_m) begin
            state_d = S_CALC;
            cnt_d   = 5'd0;
            hi_d    = '0;
            lo_d    = neg_a ? -v1 : v1;
            b_d     = neg_b ? -v2 : v2;
            mop_d   = op;
            neg_a_d = neg_a;
            neg_b_d = neg_b;
            tag_d   = alu_rob_id;
          end
        end
        S_CALC: begin
          if (mop_q[2]) begin
            if (!div_trial[33]) begin
              hi_d = div_trial[32:0];
              lo_d = {lo_q[30:0], 1'b1};
            end else begin
              hi_d = div_shift;
              lo_d = {lo_q[30:0], 1'b0};
            end
          end else begin
            hi_d = {1'b0, mul_sum[32:1]};
            lo_d = {mul_sum[0], lo_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A zero divisor yields an all-ones quotient regardless of dividend sign.
  always_comb begin
    prod_mag = {hi_d[31:0], lo_d};
    prod     = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
    quo      = ((neg_a_q ^ neg_b_q) && (b_q != 32'd0)) ? -lo_d : lo_d;
    rem      = neg_a_q ? -hi_d[31:0] : hi_d[31:0];
    case (mop_q)
      3'b000:          m_res = prod[31:0];
      3'b001, 3'b010,
      3'b011:          m_res = prod[63:32];
      3'b100, 3'b101:  m_res = quo;
      default:         m_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      mop_q   <= 3'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      mop_q   <= mop_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      tag_q   <= tag_d;
    end
  end
`else
  logic unused_op_m;

  assign unused_op_m = op_m;
  assign is_m        = 1'b0;
  assign idle        = 1'b1;
  assign alu_busy    = 1'b0;
  assign m_done      = 1'b0;
  assign m_tag       = '0;
  assign m_res       = '0;
`endif

  always_comb begin
    rs_ready_d = rs_ready_q;
    rob_id_d   = rob_id_q;
    value_d    = value_q;
    if (rob_clear) begin
      rs_ready_d = 1'b0;
    end else if (rdy) begin
      rs_ready_d = 1'b0;
      if (idle && valid && !is_m) begin
        rs_ready_d = 1'b1;
        rob_id_d   = alu_rob_id;
        value_d    = base_res;
      end else if (m_done) begin
        rs_ready_d = 1'b1;
        rob_id_d   = m_tag;
        value_d    = m_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_ready_q <= 1'b0;
      rob_id_q   <= '0;
      value_q    <= '0;
    end else begin
      rs_ready_q <= rs_ready_d;
      rob_id_q   <= rob_id_d;
      value_q    <= value_d;
    end
  end

  assign rs_ready  = rs_ready_q;
  assign rs_rob_id = rob_id_q;
  assign rs_value  = value_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed and random ops, expected results queued at issue and
// matched by a monitor on the result bus. M-extension scenarios run when ALU_M_EXT_EN is defined.
`timescale 1ns/1ps
module tb_alu_unit;
  localparam int RW = 4;
  localparam int W  = 16 + RW + 32;
  localparam logic [6:0] R_T = 7'b0110011;
  localparam logic [6:0] I_T = 7'b0010011;
  localparam logic [6:0] B_T = 7'b1100011;

  logic          clk = 1'b0, rst = 1'b0, rdy = 1'b0, rob_clear = 1'b0, valid = 1'b0;
  logic          op_other = 1'b0, op_m = 1'b0;
  logic [RW-1:0] alu_rob_id = '0;
  logic [2:0]    op = 3'd0;
  logic [6:0]    instr_type = 7'd0;
  logic [31:0]   v1 = 32'd0, v2 = 32'd0;
  logic          alu_busy, rs_ready;
  logic [RW-1:0] rs_rob_id;
  logic [31:0]   rs_value;

  alu_unit #(.ROB_SIZE_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .valid(valid),
    .alu_rob_id(alu_rob_id), .op(op), .instr_type(instr_type), .op_other(op_other),
    .op_m(op_m), .v1(v1), .v2(v2), .alu_busy(alu_busy), .rs_ready(rs_ready),
    .rs_rob_id(rs_rob_id), .rs_value(rs_value)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_cmp = 0, n_err = 0, n_seen = 0;
  logic [RW-1:0] tag_ctr = '0;
  logic [W-1:0]  exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [6:0] it, input logic [2:0] f3,
                                          input logic oth, input logic m,
                                          input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [63:0] pu;
    sa = a;
    sb = b;
`ifdef ALU_M_EXT_EN
    if (it == R_T && m) begin
      case (f3)
        3'd0: return a * b;
        3'd1: begin pu = longint'(sa) * longint'(sb); return pu[63:32]; end
        3'd2: begin pu = longint'(sa) * longint'({32'd0, b}); return pu[63:32]; end
        3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
        3'd4: begin
          if (b == 0) return 32'hFFFF_FFFF;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          return sa / sb;
        end
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 0) return a;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return sa % sb;
        end
        default: return (b == 0) ? a : a % b;
      endcase
    end
`endif
    if (it == R_T || it == I_T) begin
      case (f3)
        3'd0: return (it == R_T && oth) ? a - b : a + b;
        3'd1: return a << b[4:0];
        3'd2: return (sa < sb) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: begin
          if (oth) return sa >>> b[4:0];
          return a >> b[4:0];
        end
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    if (it == B_T) begin
      case (f3)
        3'd0: return (a == b) ? 32'd1 : 32'd0;
        3'd1: return (a != b) ? 32'd1 : 32'd0;
        3'd4: return (sa < sb) ? 32'd1 : 32'd0;
        3'd5: return (sa >= sb) ? 32'd1 : 32'd0;
        3'd6: return (a < b) ? 32'd1 : 32'd0;
        3'd7: return (a >= b) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; the op is accepted at the next edge with rdy high.
  task automatic issue(input logic [6:0] it, input logic [2:0] f3, input logic oth, input logic m,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                       input int lat, input int stall, input bit want);
    instr_type = it; op = f3; op_other = oth; op_m = m; v1 = a; v2 = b;
    alu_rob_id = tag_ctr;
    valid = 1'b1;
    repeat (stall) begin
      rdy = 1'b0;
      tick();
    end
    rdy = 1'b1;
    if (want) exp_q.push_back({16'(cyc + lat), tag_ctr, expv});
    tick();
    valid = 1'b0;
    tag_ctr = tag_ctr + 1'b1;
  endtask

  task automatic send(input logic [6:0] it, input logic [2:0] f3, input logic oth, input logic m,
                      input logic [31:0] a, input logic [31:0] b, input int stall);
    issue(it, f3, oth, m, a, b, ref_alu(it, f3, oth, m, a, b), 1, stall, 1'b1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (alu_busy && n < max_cycles) begin
      n++;
      tick();
    end
    if (alu_busy) check("wait_idle_timeout", 64'(alu_busy), 64'd0);
  endtask

  // M op with measured busy window.
  task automatic m_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expv);
    int n;
    issue(R_T, f3, 1'b0, 1'b1, a, b, expv, 33, 0, 1'b1);
    n = 0;
    while (alu_busy && n < 60) begin
      n++;
      tick();
    end
    check("busy_cycles", 64'(n), 64'd33);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_e;
  bit           pending = 1'b0;
  int           first_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      pending = 1'b0;
    end else if (rs_ready) begin
      if (!pending) begin
        pending    = 1'b1;
        first_seen = cyc;
      end
      if (rdy) begin
        pending = 1'b0;
        n_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: tag 0x%0h value 0x%0h with nothing expected (cycle %0d)",
                   rs_rob_id, rs_value, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_tag", 64'(rs_rob_id), 64'(mon_e[32 +: RW]));
          check("result_value", 64'(rs_value), 64'(mon_e[31:0]));
          check("result_latency", 64'(first_seen), 64'(mon_e[W-1 -: 16]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int seen0;
    int n;
    logic [6:0] it;
    logic [2:0] f3;
    logic       mm;

    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rs_ready", 64'(rs_ready), 64'd0);
    check("reset_rs_rob_id", 64'(rs_rob_id), 64'd0);
    check("reset_rs_value", 64'(rs_value), 64'd0);
    check("reset_alu_busy", 64'(alu_busy), 64'd0);
    rst = 1'b1;
    tick();

    // directed single-cycle ops, back to back
    tag_ctr = 4'd3;
    issue(R_T, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1, 0, 1'b1);
    issue(R_T, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0, 1'b1);
    issue(I_T, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 1, 0, 1'b1);
    issue(R_T, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 0, 1'b1);
    issue(R_T, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, 0, 1'b1);
    issue(R_T, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0, 1'b1);
    issue(R_T, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1'b1);
    issue(B_T, 3'b101, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd1, 1, 0, 1'b1);
    issue(B_T, 3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1'b1);
    issue(B_T, 3'b010, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 1, 0, 1'b1);
    issue(7'b0000011, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 1, 0, 1'b1);
    issue(I_T, 3'b001, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1, 0, 1'b1);
`ifndef ALU_M_EXT_EN
    issue(R_T, 3'b000, 1'b0, 1'b1, 32'd5, 32'd7, 32'd12, 1, 0, 1'b1);
`endif

    // op presented together with a flush is dropped
    tick();
    seen0 = n_seen;
    rob_clear = 1'b1;
    issue(R_T, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1, 0, 1'b0);
    rob_clear = 1'b0;
    repeat (3) tick();
    check("flush_drops_op", 64'(n_seen), 64'(seen0));

    // random single-cycle ops with occasional rdy stalls and idle gaps
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: it = R_T;
        3, 4, 5: it = I_T;
        6, 7, 8: it = B_T;
        default: it = 7'($urandom_range(0, 127));
      endcase
      f3 = 3'($urandom_range(0, 7));
`ifdef ALU_M_EXT_EN
      mm = (it == R_T) ? 1'b0 : 1'($urandom_range(0, 1));
`else
      mm = 1'($urandom_range(0, 1));
`endif
      send(it, f3, 1'($urandom_range(0, 1)), mm, rnd_opnd(), rnd_opnd(),
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 7) == 0) tick();
    end

`ifdef ALU_M_EXT_EN
    // directed M ops
    m_op(3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    m_op(3'b011, 32'hFFFF_FFFF, 32'd3, 32'd2);
    m_op(3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
    m_op(3'b110, 32'd7, 32'd0, 32'd7);
    m_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    m_op(3'b111, 32'd100, 32'd7, 32'd2);
    m_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    m_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    m_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = rnd_opnd();
      b  = rnd_opnd();
      m_op(f3, a, b, ref_alu(R_T, f3, 1'b0, 1'b1, a, b));
    end

    // flush at T+10 of a DIV
    seen0 = n_seen;
    issue(R_T, 3'b100, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0, 33, 0, 1'b0);
    repeat (9) tick();
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    check("flush_busy_clear", 64'(alu_busy), 64'd0);
    repeat (40) tick();
    check("flush_no_result", 64'(n_seen), 64'(seen0));

    // 5 stalled cycles mid-CALC stretch latency to T+38
    issue(R_T, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 38, 0, 1'b1);
    repeat (4) tick();
    rdy = 1'b0;
    repeat (5) tick();
    rdy = 1'b1;
    wait_idle(60);
    tick();

    // async reset in the middle of CALC
    issue(R_T, 3'b000, 1'b0, 1'b1, 32'd9, 32'd9, 32'd81, 33, 0, 1'b0);
    repeat (10) tick();
    check("busy_before_reset", 64'(alu_busy), 64'd1);
`else
    issue(R_T, 3'b110, 1'b0, 1'b0, 32'h0000_0A00, 32'h0000_000B, 32'h0000_0A0B, 1, 0, 1'b1);
    tick();
`endif
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_rs_ready", 64'(rs_ready), 64'd0);
    check("async_rst_rs_rob_id", 64'(rs_rob_id), 64'd0);
    check("async_rst_rs_value", 64'(rs_value), 64'd0);
    check("async_rst_alu_busy", 64'(alu_busy), 64'd0);
    tick();
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(R_T, 3'b100, 1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1, 0, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      n++;
      tick();
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Execution unit directly downstream of the reservation station. It accepts one ready operation per cycle: register-register, register-immediate, or branch compare. It registers the result and broadcasts it on the RS result bus (`rs_ready`/`rs_rob_id`/`rs_value`), which the RoB, LSB and RS itself snoop. Under `ALU_M_EXT_EN` it also runs RV32M multiply/divide through a 32-iteration sequential datapath, with back-pressure to the RS.

## Interface
- `XLEN`, 32: operand/result width; fixed at 32.
- `ROB_SIZE_WIDTH`, `` `ROB_SIZE_WIDTH``: RoB tag width, taken from config.v.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-low; clears all state while low.
- `rdy` in 1: global enable. When low, all state holds and inputs are ignored.
- `rob_clear` in 1: flush; synchronous, takes priority over every other input except `rst`.
- `valid` in 1: RS presents an executable operation this cycle.
- `alu_rob_id` in ROB_SIZE_WIDTH: destination RoB tag.
- `op` in 3: funct3.
- `instr_type` in 7: opcode class; one of `` `R_TYPE``, `` `I_TYPE``, `` `B_TYPE``.
- `op_other` in 1: instr[30]; selects SUB and SRA.
- `op_m` in 1: instr[25]; marks an RV32M op when `instr_type` is `` `R_TYPE``.
- `v1`, `v2` in 32: operands; `v2` holds the immediate for I-type.
- `alu_busy` out 1: sequential M op in flight. The RS must not assert `valid` while this is high.
- `rs_ready` out 1: result valid; one-cycle pulse.
- `rs_rob_id` out ROB_SIZE_WIDTH: tag of the result.
- `rs_value` out 32: result. For a branch it is the taken flag, 1 or 0.

## Operation
- Reset values: `rs_ready`=0, `rs_rob_id`=0, `rs_value`=0, `alu_busy`=0. Reset also sets FSM=IDLE and cnt=0.
- FSM states:
  - IDLE: single-cycle ops.
  - CALC: M op iterating; cnt counts 0..31.
  - DONE: M result driven.
- Accept condition: `valid && rdy && !rob_clear` while in IDLE.
- Single-cycle path. The result is registered, so `rs_ready`=1 in the cycle after accept; otherwise `rs_ready`=0.
- R/I-type, decoded by funct3:
  - 000: ADD, or SUB when R-type and `op_other`. The I-type `op_other` bit is ignored for ADDI.
  - 001: SLL.
  - 010: SLT, signed.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when `op_other`.
  - 110: OR.
  - 111: AND.
- Shift amount is `v2[4:0]`. Arithmetic wraps modulo 2^32.
- B-type, result 1 when taken:
  - 000: BEQ.
  - 001: BNE.
  - 100: BLT.
  - 101: BGE.
  - 110: BLTU.
  - 111: BGEU.
  - funct3 010/011 produce 0.
- Any other `instr_type` still accepts the op and returns `rs_value`=0 with `rs_ready`=1.
- M path (only when compiled in): accepting an R-type op with `op_m`=1 goes IDLE→CALC.
  - Latches operand magnitudes, sign flags, funct3 and tag.
  - CALC runs 32 shift-add (MUL*) or restoring-subtract (DIV*/REM*) iterations, one per cycle, then goes to DONE.
  - DONE applies the sign fix-up, registers the result with `rs_ready`=1 for one cycle, then returns to IDLE.
- `alu_busy` = (state != IDLE).
- Division corner cases:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
  - Neither case is special-cased in timing; both still take 33 cycles.
- `rob_clear`: next state IDLE, `rs_ready`=0, the in-flight M op is discarded, and any op presented in the same cycle is dropped.
- `valid` asserted while `alu_busy`=1 is a protocol error. The op is ignored and the result is undefined for verification purposes.

## Timing
- Single-cycle op accepted in cycle T → `rs_ready`=1 in T+1. Back-to-back accepts give results every cycle.
- M op accepted in cycle T:
  - `alu_busy`=1 in T+1..T+33.
  - CALC covers T+1..T+32.
  - `rs_ready`=1 in T+33 (DONE).
  - IDLE again in T+34, when the next accept is possible.
- `rdy` low in any cycle freezes the FSM, cnt and output registers. The result pulse is extended while frozen and the latency stretches by the number of stalled cycles.
- Asynchronous `rst` low mid-CALC: outputs clear immediately. The first accept is possible on the first edge after release.

## Configuration
- `ALU_M_EXT_EN` defined: RV32M path, FSM CALC/DONE and `alu_busy` are implemented as above.
- `ALU_M_EXT_EN` not defined:
  - `op_m` is ignored and ops decode as base RV32I.
  - `alu_busy` is tied to 0.
  - FSM reduces to IDLE.
  - No multiply/divide hardware.

## Test plan
- ADD/SUB: R-type funct3=000, v1=5, v2=7, op_other=0, tag 3 → next cycle `rs_ready`=1, tag 3, value 12. With op_other=1 → 0xFFFFFFFE.
- Shifts/compare: SRA v1=0x80000000, v2=4 → 0xF8000000. SLT v1=-1, v2=1 → 1. SLTU with the same operands → 0.
- Branch: BGE v1=-3, v2=-3 → value 1. BLTU v1=0xFFFFFFFF, v2=1 → value 0. Four back-to-back ops → four consecutive result pulses in order.
- M ext (`ALU_M_EXT_EN`): MUL 0xFFFFFFFF×3 → 0xFFFFFFFD. MULHU with the same operands → 2. `alu_busy` is high for 33 cycles and the result arrives at T+33.
- Division corners: DIV 7/0 → 0xFFFFFFFF. REM 7/0 → 7. DIV 0x80000000/-1 → 0x80000000. REMU 100/7 → 2.
- Flush/stall: `rob_clear` at T+10 of a DIV → no result pulse and `alu_busy`=0 next cycle. `rdy` low for 5 cycles mid-CALC → result at T+38. Async `rst` low mid-CALC → all outputs 0 immediately.
